cache_axi_bridge: RTL and testbench

Bus-side responder for the cache's refill/writeback request interface. Accepts cache-line reads and writebacks, plus single uncached byte, halfword and word accesses. Converts them into AXI4 master bursts (read channel plus write channel) and returns refill data beat by beat. Sits between the two-way data cache and the SoC AXI interconnect; one outstanding read and one outstanding write at a time.

---
 rtl/cache_axi_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: turns cache refill/writeback/uncached requests into AXI4
// master bursts. One outstanding read and one outstanding write at a time.
// Optional build macro: CACHE_AXI_RAW_CHECK_EN. When defined, a read is held off
// while a write to the same 16-byte line is pending or is being requested.
//
// Read FSM
//   state  | meaning
//   R_IDLE | ready for a read request
//   R_AR   | AR channel valid, waiting for arready
//   R_DATA | forwarding R beats until rlast
// Write FSM
//   state  | meaning
//   W_IDLE | ready for a write request
//   W_SEND | AW and W channels run independently until both are done
//   W_RESP | waiting for the B response
module cache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    r_state_t     r_state;
    w_state_t     w_state;
    logic [127:0] wbuf;
    logic [1:0]   beat;
    logic         aw_done;
    logic         w_done;
    logic         rd_line;
    logic         wr_line;
    logic         aw_hs;
    logic         w_hs;
    logic         unused_resp;

    // Response ids and status are deliberately not inspected.
    assign unused_resp = ^{rid, rresp, bid, bresp};

    assign rd_line = (rd_type == 3'd4);
    assign wr_line = (wr_type == 3'd4);
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    assign arid    = RD_ID;
    assign awid    = WR_ID;
    assign arburst = 2'b01;
    assign awburst = 2'b01;

    // Refill beats pass straight through; gating with rready keeps them quiet outside R_DATA.
    assign ret_valid = rready & rvalid;
    assign ret_last  = rready & rlast;
    assign ret_data  = rdata;

    assign wdata = wbuf[{beat, 5'b0} +: 32];
    assign wlast = (beat == awlen[1:0]);

    assign wr_rdy = (w_state == W_IDLE);

`ifdef CACHE_AXI_RAW_CHECK_EN
    logic raw_pending;
    logic raw_same;
    assign raw_pending = (w_state != W_IDLE) && (rd_addr[31:4] == awaddr[31:4]);
    assign raw_same    = wr_req && (wr_addr[31:4] == rd_addr[31:4]);
    assign rd_rdy      = (r_state == R_IDLE) && !raw_pending && !raw_same;
`else
    assign rd_rdy = (r_state == R_IDLE);
`endif

    // Read FSM: latch request, issue AR, then stream R beats until rlast.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            araddr  <= 32'd0;
            arlen   <= 8'd0;
            arsize  <= 3'd0;
        end else begin
            case (r_state)
                R_IDLE: if (rd_req && rd_rdy) begin
                    araddr  <= rd_line ? {rd_addr[31:4], 4'b0} : rd_addr;
                    arlen   <= rd_line ? 8'd3 : 8'd0;
                    arsize  <= rd_line ? 3'd2 : {1'b0, rd_type[1:0]};
                    arvalid <= 1'b1;
                    r_state <= R_AR;
                end
                R_AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    r_state <= R_DATA;
                end
                R_DATA: if (rvalid && rlast) begin
                    rready  <= 1'b0;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: latch request, run AW and W independently, then wait for B.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            awaddr  <= 32'd0;
            awlen   <= 8'd0;
            awsize  <= 3'd0;
            wstrb   <= 4'd0;
            wbuf    <= 128'd0;
            beat    <= 2'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (wr_req) begin
                    awaddr  <= wr_line ? {wr_addr[31:4], 4'b0} : wr_addr;
                    awlen   <= wr_line ? 8'd3 : 8'd0;
                    awsize  <= wr_line ? 3'd2 : {1'b0, wr_type[1:0]};
                    wstrb   <= wr_line ? 4'hf : wr_wstrb;
                    wbuf    <= wr_data;
                    beat    <= 2'd0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    w_state <= W_SEND;
                end
                W_SEND: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        beat <= beat + 2'd1;
                        if (wlast) begin
                            wvalid <= 1'b0;
                            w_done <= 1'b1;
                        end
                    end
                    // Both channels may finish on the same edge.
                    if ((aw_done || aw_hs) && (w_done || (w_hs && wlast))) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (bvalid) begin
                    bready  <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
module tb_cache_axi_bridge;

`ifdef CACHE_AXI_RAW_CHECK_EN
    localparam bit RAW = 1'b1;
`else
    localparam bit RAW = 1'b0;
`endif

    logic         clk;
    logic         resetn;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    int checks;
    int failures;

    cache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read transaction against an ideal slave; directed=1 gives a zero-wait
    // slave returning 0x11,0x22,... Entered and left mid-cycle, before the next edge.
    task automatic do_read(input logic [31:0] addr, input logic [2:0] typ, input bit directed);
        bit          line;
        int          n;
        int          dly;
        logic [31:0] exp_addr;
        logic [31:0] d;
        line     = (typ == 3'd4);
        n        = line ? 4 : 1;
        exp_addr = line ? {addr[31:4], 4'h0} : addr;
        rd_req = 1'b1; rd_type = typ; rd_addr = addr;
        #1 chk("rd_rdy_before", rd_rdy, 1);
        @(posedge clk); #1 rd_req = 1'b0;
        #1;
        chk("arvalid_after_accept", arvalid, 1);
        chk("araddr", araddr, exp_addr);
        chk("arlen", arlen, line ? 3 : 0);
        chk("arsize", arsize, line ? 2 : typ[1:0]);
        chk("arburst", arburst, 1);
        chk("arid", arid, 0);
        chk("rd_rdy_busy", rd_rdy, 0);
        chk("rready_before_ar", rready, 0);
        dly = directed ? 0 : $urandom_range(0, 3);
        repeat (dly) begin
            @(posedge clk); #2;
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, exp_addr);
        end
        arready = 1'b1;
        @(posedge clk); #1 arready = 1'b0;
        #1;
        chk("arvalid_after_hs", arvalid, 0);
        chk("rready_after_hs", rready, 1);
        for (int k = 0; k < n; k++) begin
            dly = directed ? 0 : $urandom_range(0, 2);
            repeat (dly) begin
                chk("ret_valid_gap", ret_valid, 0);
                @(posedge clk); #2;
            end
            d = directed ? 32'h11 * (k + 1) : $urandom;
            rvalid = 1'b1; rdata = d; rlast = (k == n - 1); rresp = 2'($urandom);
            rid = 4'($urandom);
            #1;
            chk("ret_valid", ret_valid, 1);
            chk("ret_data", ret_data, d);
            chk("ret_last", ret_last, (k == n - 1));
            @(posedge clk); #1 rvalid = 1'b0; rlast = 1'b0;
            #1;
        end
        chk("rd_rdy_after_last", rd_rdy, 1);
        chk("rready_after_last", rready, 0);
        chk("ret_valid_after_last", ret_valid, 0);
    endtask

    // One write transaction. wpat gives wready per cycle (LSB first); aw_wait<0
    // means random awready, otherwise awready rises aw_wait cycles after W is done.
    task automatic do_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                            input logic [127:0] data, input logic [15:0] wpat, input int aw_wait);
        bit          line;
        int          n;
        int          bi;
        int          cyc;
        int          since_w;
        int          dly;
        bit          aw_seen;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        line     = (typ == 3'd4);
        n        = line ? 4 : 1;
        exp_addr = line ? {addr[31:4], 4'h0} : addr;
        exp_strb = line ? 4'hf : strb;
        wr_req = 1'b1; wr_type = typ; wr_addr = addr; wr_wstrb = strb; wr_data = data;
        #1 chk("wr_rdy_before", wr_rdy, 1);
        @(posedge clk); #1 wr_req = 1'b0;
        #1;
        chk("awvalid_after_accept", awvalid, 1);
        chk("wvalid_after_accept", wvalid, 1);
        chk("awaddr", awaddr, exp_addr);
        chk("awlen", awlen, line ? 3 : 0);
        chk("awsize", awsize, line ? 2 : typ[1:0]);
        chk("awburst", awburst, 1);
        chk("awid", awid, 1);
        chk("wr_rdy_busy", wr_rdy, 0);
        bi = 0; cyc = 0; since_w = 0; aw_seen = 1'b0;
        while (!(bi == n && aw_seen) && cyc < 100) begin
            wready = (cyc < 16) ? wpat[cyc] : 1'b1;
            if (aw_wait < 0) awready = 1'($urandom_range(0, 1));
            else             awready = (bi == n) && (since_w >= aw_wait);
            #1;
            if (bi < n) begin
                chk("wvalid", wvalid, 1);
                chk("wdata", wdata, data[32*bi +: 32]);
                chk("wlast", wlast, (bi == n - 1));
                chk("wstrb", wstrb, exp_strb);
            end else begin
                chk("wvalid_done", wvalid, 0);
            end
            chk("awvalid", awvalid, !aw_seen);
            chk("bready_early", bready, 0);
            @(posedge clk);
            if (bi == n) since_w++;
            if (wready && bi < n) bi++;
            if (awready && !aw_seen) aw_seen = 1'b1;
            cyc++;
            #2;
        end
        chk("write_budget", (cyc < 100), 1);
        awready = 1'b0; wready = 1'b0;
        chk("bready", bready, 1);
        chk("wr_rdy_resp", wr_rdy, 0);
        dly = $urandom_range(0, 2);
        repeat (dly) begin
            @(posedge clk); #2 chk("bready_hold", bready, 1);
        end
        bvalid = 1'b1; bresp = 2'($urandom); bid = 4'($urandom);
        @(posedge clk); #1 bvalid = 1'b0;
        #1;
        chk("wr_rdy_after_b", wr_rdy, 1);
        chk("bready_after_b", bready, 0);
        chk("awvalid_idle", awvalid, 0);
        chk("wvalid_idle", wvalid, 0);
    endtask

    initial begin
        logic [2:0]   typ;
        logic [127:0] d128;
        checks = 0; failures = 0;
        resetn = 1'b0;
        rd_req = 0; rd_type = 0; rd_addr = 0;
        wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset state
        #3;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_last", ret_last, 0);
        chk("rst_rd_rdy", rd_rdy, 1);
        chk("rst_wr_rdy", wr_rdy, 1);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_awlen", awlen, 0);
        chk("rst_wstrb", wstrb, 0);
        #9 resetn = 1'b1;
        @(posedge clk); #2;

        // Directed reads
        do_read(32'h1C000010, 3'd4, 1'b1);
        do_read(32'hBFAF8003, 3'd0, 1'b1);

        // Directed writes
        do_write(32'h1C000040, 3'd4, 4'h0, 128'h00000044_00000033_00000022_00000011,
                 16'b0000_0000_0011_0101, 0);
        do_write(32'h80001234, 3'd2, 4'b0110, 128'h0123_4567_89ab_cdef_0f1e_2d3c_cafe_f00d,
                 16'hffff, 3);

        // Read-after-write hazard behaviour
        wr_req = 1'b1; wr_type = 3'd4; wr_addr = 32'h00001000; wr_wstrb = 4'h0;
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        rd_addr = 32'h00001004;
        #1;
        chk("raw_same_cycle", rd_rdy, RAW ? 0 : 1);
        chk("raw_wr_rdy", wr_rdy, 1);
        @(posedge clk); #1 wr_req = 1'b0; rd_addr = 32'h00001008;
        #1;
        repeat (3) begin
            chk("raw_pending", rd_rdy, RAW ? 0 : 1);
            rd_addr = 32'h00002000;
            #1 chk("raw_other_line", rd_rdy, 1);
            rd_addr = 32'h00001008;
            @(posedge clk); #2;
        end
        wready = 1'b1; awready = 1'b1;
        repeat (4) begin
            @(posedge clk); #2;
            chk("raw_sending", rd_rdy, RAW ? 0 : 1);
        end
        wready = 1'b0; awready = 1'b0;
        chk("raw_bready", bready, 1);
        bvalid = 1'b1;
        #1 chk("raw_resp", rd_rdy, RAW ? 0 : 1);
        @(posedge clk); #1 bvalid = 1'b0;
        #1;
        chk("raw_release", rd_rdy, 1);
        chk("raw_wr_done", wr_rdy, 1);
        do_read(32'h00001008, 3'd4, 1'b0);

        // Randomized reads and writes
        for (int i = 0; i < 10; i++) begin
            typ = 3'($urandom_range(0, 3));
            if (typ == 3'd3) typ = 3'd4;
            do_read($urandom, typ, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            typ = 3'($urandom_range(0, 3));
            if (typ == 3'd3) typ = 3'd4;
            d128 = {$urandom, $urandom, $urandom, $urandom};
            do_write($urandom, typ, 4'($urandom), d128, 16'($urandom),
                     ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 2));
        end

        // Reset mid-burst with a concurrent write in flight
        rd_req = 1'b1; rd_type = 3'd4; rd_addr = 32'h1C000020;
        wr_req = 1'b1; wr_type = 3'd4; wr_addr = 32'h00003000;
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1 rd_req = 1'b0; wr_req = 1'b0; arready = 1'b1;
        #1;
        chk("conc_awvalid", awvalid, 1);
        chk("conc_arvalid", arvalid, 1);
        @(posedge clk); #1 arready = 1'b0; rvalid = 1'b1; rdata = 32'hA;
        @(posedge clk); #1 rdata = 32'hB;
        @(posedge clk); #1 rdata = 32'hC;
        #1 chk("pre_rst_ret_valid", ret_valid, 1);
        #1 resetn = 1'b0;
        #1;
        chk("async_rready", rready, 0);
        chk("async_arvalid", arvalid, 0);
        chk("async_ret_valid", ret_valid, 0);
        chk("async_awvalid", awvalid, 0);
        chk("async_wvalid", wvalid, 0);
        rvalid = 1'b0;
        @(posedge clk); #2 resetn = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_rd_rdy", rd_rdy, 1);
        chk("post_rst_wr_rdy", wr_rdy, 1);
        do_read(32'h1C000020, 3'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
